// File: rtl/motor_mix_scheduler_pkg.sv
`default_nettype none
//==============================================================================
// Package : motor_mix_pkg
// Brief   : Shared widths, term indices and state encodings for the motor mixer.
// Rev     : 1.0 - initial release
//==============================================================================
package motor_mix_pkg;

  localparam int DUTY_W     = 8;
  localparam int OFF_W      = 9;
  localparam int ACC_W      = 12;
  localparam int NUM_MOTORS = 4;

  localparam logic [1:0] TERM_THR   = 2'd0;
  localparam logic [1:0] TERM_PITCH = 2'd1;
  localparam logic [1:0] TERM_ROLL  = 2'd2;
  localparam logic [1:0] TERM_YAW   = 2'd3;

  typedef enum logic [1:0] {
    MIX_IDLE   = 2'd0,
    MIX_SUM    = 2'd1,
    MIX_COMMIT = 2'd2
  } mix_state_t;

  typedef enum logic [1:0] {
    ARM_DISARMED = 2'd0,
    ARM_ARMING   = 2'd1,
    ARM_ARMED    = 2'd2,
    ARM_FAILSAFE = 2'd3
  } arm_state_t;

  function automatic logic [ACC_W-1:0] zext_thr(input logic [DUTY_W-1:0] v);
    return {{(ACC_W-DUTY_W){1'b0}}, v};
  endfunction

  function automatic logic [ACC_W-1:0] sext_off(input logic [OFF_W-1:0] v);
    return {{(ACC_W-OFF_W){v[OFF_W-1]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/motor_mix_scheduler_if.sv
`default_nettype none
//==============================================================================
// Interface : motor_mix_scheduler_if
// Brief     : Frame/offset inputs and duty/status outputs of the motor mixer.
// Rev       : 1.0 - initial release
//==============================================================================
interface motor_mix_scheduler_if;

  logic                                                         frame_start;
  logic                                                         rx_valid;
  logic                                                         arm_req;
  logic [motor_mix_pkg::NUM_MOTORS*motor_mix_pkg::DUTY_W-1:0]   throttle_off;
  logic [motor_mix_pkg::NUM_MOTORS*motor_mix_pkg::OFF_W-1:0]    pitch_off;
  logic [motor_mix_pkg::NUM_MOTORS*motor_mix_pkg::OFF_W-1:0]    roll_off;
  logic [motor_mix_pkg::NUM_MOTORS*motor_mix_pkg::OFF_W-1:0]    yaw_off;
  logic [motor_mix_pkg::NUM_MOTORS*motor_mix_pkg::DUTY_W-1:0]   duty;
  logic                                                         duty_valid;
  logic                                                         busy;
  logic                                                         armed;
  logic                                                         failsafe;
  logic                                                         overrun;

  modport master (
    output frame_start, rx_valid, arm_req, throttle_off, pitch_off, roll_off, yaw_off,
    input  duty, duty_valid, busy, armed, failsafe, overrun
  );

  modport slave (
    input  frame_start, rx_valid, arm_req, throttle_off, pitch_off, roll_off, yaw_off,
    output duty, duty_valid, busy, armed, failsafe, overrun
  );

endinterface
`default_nettype wire

// File: rtl/motor_mix_scheduler_arm_fsm.sv
`default_nettype none
//==============================================================================
// Module : mix_arm_fsm
// Brief  : Arming / failsafe state machine, advanced once per accepted frame.
// Rev    : 1.0 - initial release
//==============================================================================
module mix_arm_fsm
  import motor_mix_pkg::*;
#(
  parameter int ARM_FRAMES      = 16,
  parameter int FAILSAFE_FRAMES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic eval,
  input  logic qual,
  input  logic rx_valid,
  input  logic arm_req,
  output logic armed,
  output logic failsafe
);

  localparam int c_arm_cw  = $clog2(ARM_FRAMES + 1);
  localparam int c_loss_cw = $clog2(FAILSAFE_FRAMES + 1);
  localparam logic [c_arm_cw-1:0]  c_arm_done = c_arm_cw'(ARM_FRAMES);
  localparam logic [c_loss_cw-1:0] c_loss_max = c_loss_cw'(FAILSAFE_FRAMES);

  arm_state_t            r_state;
  arm_state_t            w_state_nxt;
  logic [c_arm_cw-1:0]   r_arm_cnt;
  logic [c_arm_cw-1:0]   w_arm_cnt_nxt;
  logic [c_arm_cw-1:0]   w_arm_inc;
  logic [c_loss_cw-1:0]  r_loss_cnt;
  logic [c_loss_cw-1:0]  w_loss_cnt_nxt;

  assign w_arm_inc = r_arm_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARM_DISARMED;
      r_arm_cnt  <= '0;
      r_loss_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_arm_cnt  <= w_arm_cnt_nxt;
      r_loss_cnt <= w_loss_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_arm_cnt_nxt  = r_arm_cnt;
    w_loss_cnt_nxt = r_loss_cnt;
    if (eval) begin
      if (rx_valid) begin
        w_loss_cnt_nxt = '0;
      end else if (r_loss_cnt != c_loss_max) begin
        w_loss_cnt_nxt = r_loss_cnt + 1'b1;
      end
      case (r_state)
        ARM_DISARMED: begin
          if (qual) begin
            w_state_nxt   = ARM_ARMING;
            w_arm_cnt_nxt = c_arm_cw'(1);
          end
        end
        ARM_ARMING: begin
          if (!qual) begin
            w_state_nxt   = ARM_DISARMED;
            w_arm_cnt_nxt = '0;
          end else if (w_arm_inc == c_arm_done) begin
            w_state_nxt   = ARM_ARMED;
            w_arm_cnt_nxt = '0;
          end else begin
            w_arm_cnt_nxt = w_arm_inc;
          end
        end
        ARM_ARMED: begin
          // Link loss outranks a disarm request so the failsafe state is visible.
          if (w_loss_cnt_nxt == c_loss_max) begin
            w_state_nxt = ARM_FAILSAFE;
          end else if (!arm_req) begin
            w_state_nxt = ARM_DISARMED;
          end
        end
        ARM_FAILSAFE: begin
          if (rx_valid && !arm_req) begin
            w_state_nxt = ARM_DISARMED;
          end
        end
        default: w_state_nxt = ARM_DISARMED;
      endcase
    end
  end

  assign armed    = (r_state == ARM_ARMED);
  assign failsafe = (r_state == ARM_FAILSAFE);

endmodule
`default_nettype wire

// File: rtl/motor_mix_scheduler.sv
`default_nettype none
//==============================================================================
// Module : motor_mix_scheduler
// Brief  : Per-frame snapshot, single-adder mixing, saturation and atomic commit.
// Rev    : 1.0 - initial release
//==============================================================================
module motor_mix_scheduler
  import motor_mix_pkg::*;
#(
  parameter int IDLE_DUTY       = 10,
  parameter int ARM_THR_MAX     = 16,
  parameter int ARM_FRAMES      = 16,
  parameter int FAILSAFE_FRAMES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  motor_mix_scheduler_if.slave   bus
);

  localparam logic signed [ACC_W-1:0] c_sat_lo = ACC_W'(IDLE_DUTY);
  localparam logic signed [ACC_W-1:0] c_sat_hi = ACC_W'((1 << DUTY_W) - 1);
  localparam logic [3:0]              c_last_k = 4'd15;

  mix_state_t                        r_mix_state;
  mix_state_t                        w_mix_state_nxt;
  logic [NUM_MOTORS*DUTY_W-1:0]      r_thr_snap;
  logic [NUM_MOTORS*OFF_W-1:0]       r_pitch_snap;
  logic [NUM_MOTORS*OFF_W-1:0]       r_roll_snap;
  logic [NUM_MOTORS*OFF_W-1:0]       r_yaw_snap;
  logic [3:0]                        r_k;
  logic [ACC_W-1:0]                  r_acc;
  logic [NUM_MOTORS*DUTY_W-1:0]      r_stage;
  logic [NUM_MOTORS*DUTY_W-1:0]      r_duty;
  logic                              r_duty_valid;
  logic                              r_overrun;

  logic [1:0]                        w_motor;
  logic [1:0]                        w_term;
  logic [ACC_W-1:0]                  w_operand;
  logic [ACC_W-1:0]                  w_base;
  logic [ACC_W-1:0]                  w_sum;
  logic signed [ACC_W-1:0]           w_sum_s;
  logic [DUTY_W-1:0]                 w_sat;
  logic [NUM_MOTORS-1:0]             w_thr_ok;
  logic                              w_qual;
  logic                              w_accept;
  logic                              w_busy;
  logic                              w_armed;
  logic                              w_failsafe;

  assign w_busy   = (r_mix_state != MIX_IDLE);
  assign w_accept = bus.frame_start && !w_busy;

  for (genvar m = 0; m < NUM_MOTORS; m++) begin : g_thr_qual
    assign w_thr_ok[m] = ({1'b0, bus.throttle_off[m*DUTY_W +: DUTY_W]} < (DUTY_W+1)'(ARM_THR_MAX));
  end

  assign w_qual = bus.arm_req && bus.rx_valid && (&w_thr_ok);

  mix_arm_fsm #(
    .ARM_FRAMES      (ARM_FRAMES),
    .FAILSAFE_FRAMES (FAILSAFE_FRAMES)
  ) u_arm_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .eval     (w_accept),
    .qual     (w_qual),
    .rx_valid (bus.rx_valid),
    .arm_req  (bus.arm_req),
    .armed    (w_armed),
    .failsafe (w_failsafe)
  );

  // Sequence index: upper bits pick the motor, lower bits pick the term.
  assign w_motor = r_k[3:2];
  assign w_term  = r_k[1:0];

  always_comb begin
    w_operand = '0;
    case (w_term)
      TERM_THR:   w_operand = zext_thr(r_thr_snap[w_motor*DUTY_W +: DUTY_W]);
      TERM_PITCH: w_operand = sext_off(r_pitch_snap[w_motor*OFF_W +: OFF_W]);
      TERM_ROLL:  w_operand = sext_off(r_roll_snap[w_motor*OFF_W +: OFF_W]);
      TERM_YAW:   w_operand = sext_off(r_yaw_snap[w_motor*OFF_W +: OFF_W]);
      default:    w_operand = '0;
    endcase
  end

  // The throttle term starts a fresh sum through the same adder.
  assign w_base  = (w_term == TERM_THR) ? '0 : r_acc;
  assign w_sum   = w_base + w_operand;
  assign w_sum_s = w_sum;

  always_comb begin
    w_sat = w_sum[DUTY_W-1:0];
    if (w_sum_s < c_sat_lo) begin
      w_sat = c_sat_lo[DUTY_W-1:0];
    end else if (w_sum_s > c_sat_hi) begin
      w_sat = c_sat_hi[DUTY_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mix_state <= MIX_IDLE;
    end else begin
      r_mix_state <= w_mix_state_nxt;
    end
  end

  always_comb begin
    w_mix_state_nxt = r_mix_state;
    case (r_mix_state)
      MIX_IDLE:   if (bus.frame_start) w_mix_state_nxt = MIX_SUM;
      MIX_SUM:    if (r_k == c_last_k) w_mix_state_nxt = MIX_COMMIT;
      MIX_COMMIT: w_mix_state_nxt = MIX_IDLE;
      default:    w_mix_state_nxt = MIX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thr_snap   <= '0;
      r_pitch_snap <= '0;
      r_roll_snap  <= '0;
      r_yaw_snap   <= '0;
      r_k          <= '0;
      r_acc        <= '0;
      r_stage      <= '0;
      r_duty       <= '0;
      r_duty_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_duty_valid <= 1'b0;
      if (w_accept) begin
        r_thr_snap   <= bus.throttle_off;
        r_pitch_snap <= bus.pitch_off;
        r_roll_snap  <= bus.roll_off;
        r_yaw_snap   <= bus.yaw_off;
        r_k          <= '0;
      end
      if (bus.frame_start && w_busy) begin
        r_overrun <= 1'b1;
      end
      if (r_mix_state == MIX_SUM) begin
        r_k   <= r_k + 1'b1;
        r_acc <= w_sum;
        if (w_term == TERM_YAW) begin
          r_stage[w_motor*DUTY_W +: DUTY_W] <= w_sat;
        end
      end
      if (r_mix_state == MIX_COMMIT) begin
        r_duty       <= w_armed ? r_stage : '0;
        r_duty_valid <= 1'b1;
      end
    end
  end

  assign bus.duty       = r_duty;
  assign bus.duty_valid = r_duty_valid;
  assign bus.busy       = w_busy;
  assign bus.armed      = w_armed;
  assign bus.failsafe   = w_failsafe;
  assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_motor_mix_scheduler.sv
`default_nettype none
//==============================================================================
// Module : tb_motor_mix_scheduler
// Brief  : Directed self-checking bench for the motor mix scheduler.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_motor_mix_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   lat;
  logic busy_at_start;
  int   vcount;
  logic [31:0] dsnap;

  motor_mix_scheduler_if bus ();

  motor_mix_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted frame; returns once duty_valid is seen or the budget expires.
  task automatic run_frame(input logic [31:0] thr, input logic [35:0] p, input logic [35:0] r,
                           input logic [35:0] y, input logic rx, input logic arm);
    logic got;
    @(negedge clk);
    bus.throttle_off = thr;
    bus.pitch_off    = p;
    bus.roll_off     = r;
    bus.yaw_off      = y;
    bus.rx_valid     = rx;
    bus.arm_req      = arm;
    bus.frame_start  = 1'b1;
    @(negedge clk);
    bus.frame_start  = 1'b0;
    busy_at_start    = bus.busy;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (bus.duty_valid) begin
        got = 1'b1;
        lat = i;
      end
    end
    check("latency", 64'(lat), 64'd17);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.frame_start  = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.arm_req      = 1'b0;
    bus.throttle_off = '0;
    bus.pitch_off    = '0;
    bus.roll_off     = '0;
    bus.yaw_off      = '0;
    repeat (3) @(negedge clk);
    check("rst_duty", 64'(bus.duty), 64'd0);
    check("rst_valid", 64'(bus.duty_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_flags", 64'({bus.armed, bus.failsafe, bus.overrun}), 64'd0);
    rst_n = 1'b1;

    // 1: zero frame while disarmed
    run_frame('0, '0, '0, '0, 1'b0, 1'b0);
    check("t1_busy", 64'(busy_at_start), 64'd1);
    check("t1_duty", 64'(bus.duty), 64'd0);
    check("t1_armed", 64'(bus.armed), 64'd0);
    @(negedge clk);
    check("t1_pulse", 64'({bus.duty_valid, bus.busy}), 64'd0);

    // 2: arming over 16 qualifying frames
    for (int f = 1; f <= 15; f++) run_frame({4{8'd5}}, '0, '0, '0, 1'b1, 1'b1);
    check("t2_armed15", 64'(bus.armed), 64'd0);
    check("t2_duty15", 64'(bus.duty), 64'd0);
    run_frame({4{8'd5}}, '0, '0, '0, 1'b1, 1'b1);
    check("t2_armed16", 64'(bus.armed), 64'd1);
    check("t2_duty16", 64'(bus.duty), 64'h0A0A0A0A);
    run_frame({8'd0, 8'd50, 8'd200, 8'd100},
              {9'd0, 9'h1E2, 9'd0, 9'd20},
              {9'd0, 9'd0, 9'd0, 9'h1F6},
              {9'd0, 9'd0, 9'd0, 9'd5}, 1'b1, 1'b1);
    check("t2_mix", 64'(bus.duty), 64'h0A14C873);

    // 3: saturation
    run_frame({4{8'd250}}, {4{9'd100}}, {4{9'd100}}, {4{9'd100}}, 1'b1, 1'b1);
    check("t3_sat_hi", 64'(bus.duty), 64'hFFFFFFFF);
    run_frame('0, {4{9'h100}}, {4{9'h100}}, {4{9'h100}}, 1'b1, 1'b1);
    check("t3_sat_lo", 64'(bus.duty), 64'h0A0A0A0A);
    run_frame({8'd20, 8'd10, 8'd200, 8'd255}, {9'h1F5, 9'd0, 9'd56, 9'd0}, '0, '0, 1'b1, 1'b1);
    check("t3_edges", 64'(bus.duty), 64'h0A0AFFFF);

    // 4: failsafe after 8 frames of link loss
    for (int f = 1; f <= 7; f++) run_frame({4{8'd100}}, '0, '0, '0, 1'b0, 1'b1);
    check("t4_armed7", 64'({bus.armed, bus.failsafe}), 64'd2);
    check("t4_duty7", 64'(bus.duty), 64'h64646464);
    run_frame({4{8'd100}}, '0, '0, '0, 1'b0, 1'b1);
    check("t4_fs8", 64'({bus.armed, bus.failsafe}), 64'd1);
    check("t4_duty8", 64'(bus.duty), 64'd0);
    run_frame({4{8'd100}}, '0, '0, '0, 1'b1, 1'b0);
    check("t4_disarm", 64'({bus.armed, bus.failsafe}), 64'd0);

    // 5: arming abort on a high throttle, then a full fresh pass
    for (int f = 1; f <= 9; f++) run_frame({4{8'd5}}, '0, '0, '0, 1'b1, 1'b1);
    run_frame({8'd5, 8'd5, 8'd20, 8'd5}, '0, '0, '0, 1'b1, 1'b1);
    check("t5_abort", 64'(bus.armed), 64'd0);
    for (int f = 1; f <= 15; f++) run_frame({4{8'd15}}, '0, '0, '0, 1'b1, 1'b1);
    check("t5_armed15", 64'(bus.armed), 64'd0);
    run_frame({4{8'd15}}, '0, '0, '0, 1'b1, 1'b1);
    check("t5_armed16", 64'(bus.armed), 64'd1);
    check("t5_duty", 64'(bus.duty), 64'h0F0F0F0F);

    // 6a: overrun
    check("t6_ovr_pre", 64'(bus.overrun), 64'd0);
    @(negedge clk);
    bus.throttle_off = {4{8'd60}};
    bus.frame_start  = 1'b1;
    @(negedge clk);
    bus.frame_start  = 1'b0;
    repeat (4) @(negedge clk);
    bus.throttle_off = {4{8'd120}};
    bus.frame_start  = 1'b1;
    @(negedge clk);
    bus.frame_start  = 1'b0;
    check("t6_ovr", 64'(bus.overrun), 64'd1);
    vcount = 0;
    dsnap  = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.duty_valid) begin
        vcount++;
        dsnap = bus.duty;
      end
    end
    check("t6_nvalid", 64'(vcount), 64'd1);
    check("t6_duty", 64'(dsnap), 64'h3C3C3C3C);

    // 6b: asynchronous reset in the middle of SUM
    @(negedge clk);
    bus.throttle_off = {4{8'd90}};
    bus.frame_start  = 1'b1;
    @(negedge clk);
    bus.frame_start  = 1'b0;
    repeat (8) @(negedge clk);
    check("t6_busy_mid", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_duty", 64'(bus.duty), 64'd0);
    check("t6_rst_flags", 64'({bus.duty_valid, bus.busy, bus.armed, bus.failsafe, bus.overrun}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    vcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.duty_valid) vcount++;
    end
    check("t6_no_commit", 64'(vcount), 64'd0);
    check("t6_post_duty", 64'(bus.duty), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/motor_mix_scheduler.md
Name: motor_mix_scheduler

Overview:
- Frame-synchronous mixer and scheduler for the four motor PWM generators.
- Once per PWM frame it snapshots the per-motor throttle, pitch, roll and yaw offsets from the offset generators.
- It sums them through one shared, time-multiplexed adder, saturates the result, and commits all four duty words atomically.
- An arming/failsafe state machine gates whether mixed duties or zero reach the motors.

Parameters:
- DUTY_W, 8, duty and throttle-offset width (unsigned).
- OFF_W, 9, pitch/roll/yaw offset width (two's complement).
- ACC_W, 12, accumulator width (signed).
- IDLE_DUTY, 10, minimum duty while armed.
- ARM_THR_MAX, 16, every throttle offset must be strictly below this to arm.
- ARM_FRAMES, 16, consecutive qualifying frames needed to arm.
- FAILSAFE_FRAMES, 8, consecutive frames with rx_valid low that trigger failsafe.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- frame_start  in  1  one-cycle pulse at PWM period wrap.
- rx_valid  in  1  receiver link healthy (level).
- arm_req  in  1  pilot arm switch (level, pre-synchronised).
- throttle_off  in  4*DUTY_W  motor m occupies [m*8 +: 8], unsigned.
- pitch_off  in  4*OFF_W  motor m occupies [m*9 +: 9], signed.
- roll_off  in  4*OFF_W  same packing as pitch_off.
- yaw_off  in  4*OFF_W  same packing as pitch_off.
- duty  out  4*DUTY_W  committed duty to the PWM generators; motor m at [m*8 +: 8].
- duty_valid  out  1  one-cycle pulse when duty updates.
- busy  out  1  mix sequence in progress.
- armed  out  1  arm state is ARMED.
- failsafe  out  1  arm state is FAILSAFE.
- overrun  out  1  sticky; frame_start arrived while busy.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - Reset values: duty=0, duty_valid=0, busy=0, armed=0, failsafe=0, overrun=0; mix FSM in IDLE; arm FSM in DISARMED; all counters 0.
- Mix FSM states: IDLE, SUM, COMMIT.
  - IDLE: on frame_start, snapshot all four input buses into internal registers, evaluate the arm FSM once, then go to SUM with busy=1.
  - SUM: 16 cycles. Index k=0..15, motor = k>>2, term = k&3, terms ordered throttle, pitch, roll, yaw.
    - Term 0 loads the accumulator with the zero-extended throttle.
    - Terms 1-3 add the sign-extended offset.
    - Exactly one add per cycle; one adder only.
    - After term 3, the saturated result goes into that motor's staging register.
  - COMMIT: one cycle.
    - duty <= staging (all four together) if armed, else 0.
    - duty_valid=1. busy drops. Return to IDLE.
- Latency: frame_start sampled at edge t -> duty/duty_valid update at edge t+17.
- duty holds its value between commits. It never changes mid-sequence.
- Saturation of the mixed sum s (ACC_W signed; range -768..1020):
  - armed: s<IDLE_DUTY -> IDLE_DUTY; s>255 -> 255; else s[7:0].
  - not armed: 0.
- frame_start while busy: ignored (no re-snapshot, no arm evaluation); overrun <= 1. overrun clears only on reset.
- Arm FSM states: DISARMED, ARMING, ARMED, FAILSAFE. It is evaluated only at an accepted frame_start, using the snapshot values.
  - qual = arm_req & rx_valid & (all throttle_off < ARM_THR_MAX).
  - DISARMED -> ARMING if qual; arm_cnt=1.
  - ARMING: if !qual -> DISARMED, arm_cnt=0. Else arm_cnt++; at arm_cnt==ARM_FRAMES -> ARMED.
  - ARMED: !arm_req -> DISARMED. loss_cnt==FAILSAFE_FRAMES -> FAILSAFE, which takes priority over the arm_req check.
  - FAILSAFE -> DISARMED when rx_valid & !arm_req. Re-arming requires a full ARMING pass.
- loss_cnt: each accepted frame, +1 if !rx_valid (saturating at FAILSAFE_FRAMES), cleared if rx_valid. It counts in every arm state.
- The arm-state transition applies to the COMMIT of the same frame. Example: the frame that enters ARMED commits mixed duties; the frame that enters FAILSAFE commits 0.
- Reset asserted mid-sequence: everything returns to reset values immediately; no partial commit.

Decomposition:
- Shared package motor_mix_pkg:
  - mix-state and arm-state encodings.
  - DUTY_W, OFF_W, ACC_W.
  - term-index constants (TERM_THR=0, TERM_PITCH=1, TERM_ROLL=2, TERM_YAW=3).
- One sub-module, mix_arm_fsm:
  - contains the arm state machine, arm_cnt and loss_cnt.
  - inputs: clk, rst_n, eval strobe, qual, rx_valid, arm_req.
  - outputs: armed, failsafe.
- The adder, saturation logic and mix FSM stay in motor_mix_scheduler.

Test Plan:
1. Reset, then frame_start with all offsets 0 -> duty_valid at +17 cycles, duty=0, armed=0.
2. Arming: arm_req=1, rx_valid=1, throttle=5 for 16 frames -> armed=1 at the 16th accepted frame. Then throttle=100, pitch=+20, roll=-10, yaw=+5 on motor0 -> duty[7:0]=115.
3. Saturation while armed:
   - throttle=250, pitch=roll=yaw=+100 -> duty=255.
   - throttle=0, offsets=-256 -> duty=IDLE_DUTY (10).
4. Failsafe: while armed, rx_valid=0 for 8 frames -> failsafe=1 and duty=0 at that commit. Then rx_valid=1, arm_req=0 -> DISARMED.
5. Arming abort: throttle=20 (>=ARM_THR_MAX) at frame 10 of ARMING -> DISARMED; armed never asserts.
6. Overrun and reset:
   - Second frame_start 5 cycles after the first -> overrun=1; only one duty_valid; duty reflects the first snapshot.
   - rst_n low at SUM cycle 8 -> all outputs 0 asynchronously.
